float_fixed_roundtrip: RTL and testbench



---
 rtl/float_fixed_roundtrip.sv | 119 +++++++++++
 tb/tb_float_fixed_roundtrip.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/float_fixed_roundtrip.sv
// IEEE-754 single <-> signed fixed-point (Q1.WIDTH) converter pair.
// Stage 1 unpacks to fixed, stage 2 re-packs the registered fixed word.
module float_fixed_roundtrip #(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [31:0]      in_float,
    output logic [WIDTH+1:0] fixed_out,
    output logic             fixed_valid,
    output logic [31:0]      out_float,
    output logic             out_valid
);

    localparam int FW = WIDTH + 2;

    // ---------------- unpack ----------------
    logic            w_s;
    logic [7:0]      w_exp;
    logic [22:0]     w_man;
    logic [23:0]     w_mag;
    logic [8:0]      w_shift;
    logic [23:0]     w_q;
    logic [FW-1:0]   w_q_fix;
    logic [FW-1:0]   w_unpack;
    logic            w_is_zero;
    logic            w_is_sat;

    assign w_s       = in_float[31];
    assign w_exp     = in_float[30:23];
    assign w_man     = in_float[22:0];
    assign w_mag     = {1'b1, w_man};
    assign w_is_zero = (w_exp == 8'd0);
    // E >= 128 covers both |x| >= 2 and inf/NaN
    assign w_is_sat  = w_exp[7];

    // shift = 23 - WIDTH - (E - 127); non-negative whenever E <= 127
    assign w_shift = 9'(150 - WIDTH) - {1'b0, w_exp};
    assign w_q     = (w_shift >= 9'd24) ? 24'd0 : (w_mag >> w_shift);
    assign w_q_fix = w_q[FW-1:0];

    always_comb begin
        w_unpack = '0;
        if (w_is_zero) begin
            w_unpack = '0;
        end else if (w_is_sat) begin
            w_unpack = w_s ? {1'b1, {(FW-1){1'b0}}}
                           : {1'b0, {(FW-1){1'b1}}};
        end else begin
            w_unpack = w_s ? (~w_q_fix + 1'b1) : w_q_fix;
        end
    end

    logic [FW-1:0] r_fixed;
    logic          r_fixed_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fixed       <= '0;
            r_fixed_valid <= 1'b0;
        end else begin
            r_fixed       <= w_unpack;
            r_fixed_valid <= in_valid;
        end
    end

    // ---------------- pack ----------------
    logic            w_ps;
    logic [FW-1:0]   w_abs;
    logic [4:0]      w_lead;
    logic [31:0]     w_abs_ext;
    logic [31:0]     w_norm;
    logic [7:0]      w_pexp;
    logic [31:0]     w_pack;

    assign w_ps  = r_fixed[FW-1];
    // -2.0 negates to itself, which reads correctly as unsigned 2^(WIDTH+1)
    assign w_abs = w_ps ? (~r_fixed + 1'b1) : r_fixed;

    always_comb begin
        w_lead = '0;
        for (int i = 0; i < FW; i++) begin
            if (w_abs[i]) begin
                w_lead = 5'(i);
            end
        end
    end

    assign w_abs_ext = 32'(w_abs);
    assign w_norm    = w_abs_ext << (5'd23 - w_lead);
    assign w_pexp    = 8'(127 - WIDTH) + 8'(w_lead);

    always_comb begin
        w_pack = '0;
        if (r_fixed != '0) begin
            w_pack = {w_ps, w_pexp, w_norm[22:0]};
        end
    end

    logic [31:0] r_out;
    logic        r_out_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out       <= w_pack;
            r_out_valid <= r_fixed_valid;
        end
    end

    assign fixed_out   = r_fixed;
    assign fixed_valid = r_fixed_valid;
    assign out_float   = r_out;
    assign out_valid   = r_out_valid;

endmodule

// File: tb/tb_float_fixed_roundtrip.sv
// Directed round-trip bench for float_fixed_roundtrip at WIDTH=22.
module tb_float_fixed_roundtrip;

    localparam int WIDTH = 22;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic [31:0]      in_float;
    logic [WIDTH+1:0] fixed_out;
    logic             fixed_valid;
    logic [31:0]      out_float;
    logic             out_valid;

    int n_cmp;
    int n_bad;

    float_fixed_roundtrip #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_float    (in_float),
        .fixed_out   (fixed_out),
        .fixed_valid (fixed_valid),
        .out_float   (out_float),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive on the falling edge, then sample 1 time unit after the rising edge
    task automatic step(input logic v, input logic [31:0] f);
        @(negedge clk);
        in_valid = v;
        in_float = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_float = 32'h0;
        #1;
        chk("rst_fixed", 32'(fixed_out), 32'h0);
        chk("rst_fv", 32'(fixed_valid), 32'h0);
        chk("rst_out", out_float, 32'h0);
        chk("rst_ov", 32'(out_valid), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        step(1'b1, 32'h3F800000);
        chk("one_fixed", 32'(fixed_out), 32'h400000);
        chk("one_fv", 32'(fixed_valid), 32'h1);
        chk("one_ov", 32'(out_valid), 32'h0);

        step(1'b1, 32'hBF800000);
        chk("neg1_fixed", 32'(fixed_out), 32'hC00000);
        chk("one_out", out_float, 32'h3F800000);
        chk("one_ov2", 32'(out_valid), 32'h1);

        step(1'b1, 32'h3F000000);
        chk("half_fixed", 32'(fixed_out), 32'h200000);
        chk("neg1_out", out_float, 32'hBF800000);

        step(1'b1, 32'h40400000);
        chk("three_fixed", 32'(fixed_out), 32'h7FFFFF);
        chk("half_out", out_float, 32'h3F000000);

        step(1'b1, 32'hC0000000);
        chk("m2_fixed", 32'(fixed_out), 32'h800000);
        chk("three_out", out_float, 32'h3FFFFFFE);

        step(1'b1, 32'h7F800000);
        chk("inf_fixed", 32'(fixed_out), 32'h7FFFFF);
        chk("m2_out", out_float, 32'hC0000000);

        step(1'b1, 32'h00000001);
        chk("den_fixed", 32'(fixed_out), 32'h0);
        chk("inf_out", out_float, 32'h3FFFFFFE);

        step(1'b1, 32'h33000000);
        chk("tiny_fixed", 32'(fixed_out), 32'h0);
        chk("den_out", out_float, 32'h0);

        step(1'b1, 32'h3F47AE14);
        chk("s0_fixed", 32'(fixed_out), 32'h31EB85);
        chk("tiny_out", out_float, 32'h0);

        step(1'b1, 32'h3F0A9594);
        chk("s1_fixed", 32'(fixed_out), 32'h22A565);
        chk("s0_out", out_float, 32'h3F47AE14);
        chk("s0_ov", 32'(out_valid), 32'h1);

        step(1'b0, 32'h0);
        chk("idle_fv", 32'(fixed_valid), 32'h0);
        chk("s1_out", out_float, 32'h3F0A9594);
        chk("s1_ov", 32'(out_valid), 32'h1);

        step(1'b0, 32'h0);
        chk("idle_ov", 32'(out_valid), 32'h0);

        // reset lands between the two stream operands
        step(1'b1, 32'h3F47AE14);
        chk("r_s0_fixed", 32'(fixed_out), 32'h31EB85);
        chk("r_s0_fv", 32'(fixed_valid), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("ar_fixed", 32'(fixed_out), 32'h0);
        chk("ar_fv", 32'(fixed_valid), 32'h0);
        chk("ar_out", out_float, 32'h0);
        chk("ar_ov", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("hold_fv", 32'(fixed_valid), 32'h0);
        chk("hold_ov", 32'(out_valid), 32'h0);

        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_float = 32'h3F800000;
        @(posedge clk);
        #1;
        chk("post_fixed", 32'(fixed_out), 32'h400000);
        chk("post_fv", 32'(fixed_valid), 32'h1);
        chk("post_ov1", 32'(out_valid), 32'h0);

        step(1'b0, 32'h0);
        chk("post_ov2", 32'(out_valid), 32'h1);
        chk("post_out", out_float, 32'h3F800000);

        step(1'b0, 32'h0);
        chk("post_ov3", 32'(out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
